// File: rtl/proc_ctrl.sv
// proc_ctrl: control unit for the 4-bit two-register accumulate datapath.
// Accepts {op, cnt, imm} requests, drives the datapath enables/selects for
// one (LDA/LDB) or cnt+1 (ADDA/ADDB) cycles, then offers the datapath
// result on the response port until the sink takes it.
module proc_ctrl #(
   parameter int CNT_BITS = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_val,
   output logic                      req_rdy,
   input  logic [2+CNT_BITS+4-1:0]   req_msg,
   output logic                      resp_val,
   input  logic                      resp_rdy,
   output logic [3:0]                resp_msg,
   output logic                      regA_en,
   output logic                      regA_sel,
   output logic                      regB_en,
   output logic                      regB_sel,
   output logic [3:0]                imm,
   input  logic [3:0]                dpath_result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] OP_LDA  = 2'b00;
   localparam logic [1:0] OP_LDB  = 2'b01;
   localparam logic [1:0] OP_ADDA = 2'b10;
   localparam logic [1:0] OP_ADDB = 2'b11;

   localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
   localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};

   state_t                r_state;
   state_t                w_state_nxt;
   logic [1:0]            r_op;
   logic [CNT_BITS-1:0]   r_cnt;
   logic [3:0]            r_imm;

   logic [1:0]            w_req_op;
   logic [CNT_BITS-1:0]   w_req_cnt;
   logic [3:0]            w_req_imm;
   logic                  w_accept;
   logic                  w_cnt_dec;

   assign w_req_op  = req_msg[CNT_BITS+5:CNT_BITS+4];
   assign w_req_cnt = req_msg[CNT_BITS+3:4];
   assign w_req_imm = req_msg[3:0];

   // A request is taken only in IDLE; busy-time req_val is ignored.
   assign w_accept  = (r_state == IDLE) && req_val;
   // ADD ops count down while more add cycles remain.
   assign w_cnt_dec = (r_state == EXEC) && r_op[1] && (r_cnt != CNT_ZERO);

   // The controller never touches data: the result is the datapath output.
   assign resp_msg = dpath_result;
   assign imm      = r_imm;

   // State register; asynchronous reset aborts any request in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Latched instruction fields and the repeat down-counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_op  <= 2'b00;
         r_cnt <= CNT_ZERO;
         r_imm <= 4'd0;
      end else if (w_accept) begin
         r_op  <= w_req_op;
         r_cnt <= w_req_cnt;
         r_imm <= w_req_imm;
      end else if (w_cnt_dec) begin
         r_cnt <= r_cnt - CNT_ONE;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   // Next-state and state-decoded control outputs.
   always_comb begin
      w_state_nxt = r_state;
      req_rdy     = 1'b0;
      resp_val    = 1'b0;
      regA_en     = 1'b0;
      regA_sel    = 1'b0;
      regB_en     = 1'b0;
      regB_sel    = 1'b0;
      case (r_state)
         IDLE: begin
            req_rdy = 1'b1;
            if (req_val) begin
               w_state_nxt = EXEC;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         EXEC: begin
            case (r_op)
               OP_LDA: begin
                  regA_en     = 1'b1;
                  w_state_nxt = RESP;
               end
               OP_LDB: begin
                  regB_en     = 1'b1;
                  w_state_nxt = RESP;
               end
               OP_ADDA: begin
                  regA_en  = 1'b1;
                  regA_sel = 1'b1;
                  if (r_cnt == CNT_ZERO) begin
                     w_state_nxt = RESP;
                  end else begin
                     w_state_nxt = EXEC;
                  end
               end
               OP_ADDB: begin
                  regB_en  = 1'b1;
                  regB_sel = 1'b1;
                  if (r_cnt == CNT_ZERO) begin
                     w_state_nxt = RESP;
                  end else begin
                     w_state_nxt = EXEC;
                  end
               end
               default: begin
                  w_state_nxt = RESP;
               end
            endcase
         end
         RESP: begin
            resp_val = 1'b1;
            if (resp_rdy) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = RESP;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_proc_ctrl.sv
// tb_proc_ctrl: directed, table-driven bench for proc_ctrl with a small
// behavioural model of the regA/regB/adder datapath closing the loop.
module tb_proc_ctrl;

   localparam int CB = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           req_val;
   logic           req_rdy;
   logic [CB+5:0]  req_msg;
   logic           resp_val;
   logic           resp_rdy;
   logic [3:0]     resp_msg;
   logic           regA_en, regA_sel, regB_en, regB_sel;
   logic [3:0]     imm;
   logic [3:0]     dpath_result;

   logic [3:0]     m_a, m_b, m_sum;

   int n_checks = 0;
   int n_errors = 0;

   proc_ctrl #(.CNT_BITS(CB)) dut (
      .clk(clk), .reset(reset),
      .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
      .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
      .regA_en(regA_en), .regA_sel(regA_sel),
      .regB_en(regB_en), .regB_sel(regB_sel),
      .imm(imm), .dpath_result(dpath_result)
   );

   always #5 clk = ~clk;

   // Datapath model: muxes, two registers and a mod-16 adder.
   assign m_sum        = m_a + m_b;
   assign dpath_result = m_sum;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_a <= 4'd0;
         m_b <= 4'd0;
      end else begin
         if (regA_en) m_a <= regA_sel ? m_sum : imm;
         if (regB_en) m_b <= regB_sel ? m_sum : imm;
      end
   end

   typedef struct {
      logic [1:0] op;
      logic [3:0] cnt;
      logic [3:0] imm;
      logic [3:0] exp_resp;
      int         exp_en;
      int         exp_lat;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One full transaction: request, EXEC pattern, latency, response, handshake.
   task automatic do_txn(input vec_t v, input int idx);
      int   lat;
      int   en_cnt;
      int   bad;
      logic got;
      @(negedge clk);
      check($sformatf("v%0d_idle_rdy", idx), {31'd0, req_rdy}, 32'd1);
      req_msg = {v.op, v.cnt, v.imm};
      req_val = 1'b1;
      @(posedge clk);
      #1;
      req_val = 1'b0;
      req_msg = '0;
      lat = 0; en_cnt = 0; bad = 0; got = 1'b0;
      for (int k = 1; k <= 40 && !got; k++) begin
         @(negedge clk);
         if (resp_val) begin
            got = 1'b1;
            lat = k;
         end else begin
            if (req_rdy) bad++;
            if (imm !== v.imm) bad++;
            case (v.op)
               2'b00: begin
                  if (regA_en && !regA_sel) en_cnt++; else bad++;
                  if (regB_en || regB_sel) bad++;
               end
               2'b01: begin
                  if (regB_en && !regB_sel) en_cnt++; else bad++;
                  if (regA_en || regA_sel) bad++;
               end
               2'b10: begin
                  if (regA_en && regA_sel) en_cnt++; else bad++;
                  if (regB_en || regB_sel) bad++;
               end
               default: begin
                  if (regB_en && regB_sel) en_cnt++; else bad++;
                  if (regA_en || regA_sel) bad++;
               end
            endcase
         end
      end
      check($sformatf("v%0d_resp_seen", idx), {31'd0, got}, 32'd1);
      if (got) begin
         check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
         check($sformatf("v%0d_resp_msg", idx), {28'd0, resp_msg}, {28'd0, v.exp_resp});
         check($sformatf("v%0d_en_cycles", idx), en_cnt, v.exp_en);
         check($sformatf("v%0d_exec_pattern_errs", idx), bad, 0);
         check($sformatf("v%0d_resp_ctrl", idx),
               {27'd0, req_rdy, regA_en, regA_sel, regB_en, regB_sel}, 32'd0);
         resp_rdy = 1'b1;
         @(posedge clk);
         #1;
         resp_rdy = 1'b0;
         check($sformatf("v%0d_post_idle", idx), {30'd0, req_rdy, resp_val}, 32'd2);
      end
   endtask

   initial begin
      int seen;
      logic got;
      vec_t fin;

      //              op     cnt    imm    resp   en lat
      vecs[0]  = '{2'b00, 4'd0,  4'd3,  4'd3,  1, 2};   // LDA 3   A=3 B=0
      vecs[1]  = '{2'b01, 4'd0,  4'd5,  4'd8,  1, 2};   // LDB 5   A=3 B=5
      vecs[2]  = '{2'b10, 4'd0,  4'd0,  4'd13, 1, 2};   // ADDA    A=8
      vecs[3]  = '{2'b00, 4'd0,  4'd1,  4'd6,  1, 2};   // LDA 1   A=1 B=5
      vecs[4]  = '{2'b01, 4'd0,  4'd1,  4'd2,  1, 2};   // LDB 1   A=1 B=1
      vecs[5]  = '{2'b11, 4'd2,  4'd0,  4'd5,  3, 4};   // ADDB x3 B=4
      vecs[6]  = '{2'b01, 4'd0,  4'd1,  4'd2,  1, 2};   // LDB 1   B=1
      vecs[7]  = '{2'b00, 4'd0,  4'd15, 4'd0,  1, 2};   // LDA 15  15+1 wraps
      vecs[8]  = '{2'b10, 4'd0,  4'd0,  4'd1,  1, 2};   // ADDA    A=0
      vecs[9]  = '{2'b10, 4'd15, 4'd0,  4'd1,  16, 17}; // ADDA x16 A=0
      vecs[10] = '{2'b00, 4'd5,  4'd7,  4'd8,  1, 2};   // LDA 7, cnt ignored

      req_val  = 1'b0;
      resp_rdy = 1'b0;
      req_msg  = '0;
      reset    = 1'b1;
      #1 reset = 1'b0;
      #1;
      check("reset_rdy", {31'd0, req_rdy}, 32'd1);
      check("reset_resp_val", {31'd0, resp_val}, 32'd0);
      check("reset_ctrl", {28'd0, regA_en, regA_sel, regB_en, regB_sel}, 32'd0);
      check("reset_imm", {28'd0, imm}, 32'd0);
      check("reset_resp_msg", {28'd0, resp_msg}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 11; i++) begin
         do_txn(vecs[i], i);
      end

      // Backpressure: LDA 2 with B=1 gives 3, held in RESP for 5 cycles.
      @(negedge clk);
      req_msg = {2'b00, 4'd0, 4'd2};
      req_val = 1'b1;
      @(posedge clk);
      #1 req_val = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         if (resp_val) got = 1'b1;
      end
      check("bp_resp_seen", {31'd0, got}, 32'd1);
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk);
         check($sformatf("bp_hold%0d", c),
               {22'd0, resp_val, req_rdy, resp_msg, regA_en, regA_sel, regB_en, regB_sel},
               {22'd0, 1'b1, 1'b0, 4'd3, 4'b0000});
         req_msg = {2'b01, 4'd0, 4'd12};
         req_val = (c % 2 == 0);
      end
      @(negedge clk);
      req_val  = 1'b0;
      resp_rdy = 1'b1;
      @(posedge clk);
      #1 resp_rdy = 1'b0;
      check("bp_release_idle", {30'd0, req_rdy, resp_val}, 32'd2);
      repeat (3) @(negedge clk);
      check("bp_ignored_req", {29'd0, req_rdy, resp_val, regB_en}, 32'd4);
      check("bp_b_unchanged", {28'd0, m_b}, 32'd1);

      // Reset in the 3rd EXEC cycle of ADDA cnt=7.
      @(negedge clk);
      req_msg = {2'b10, 4'd7, 4'd0};
      req_val = 1'b1;
      @(posedge clk);
      #1 req_val = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_in_exec", {30'd0, regA_en, regA_sel}, 32'd3);
      #1 reset = 1'b0;
      #1;
      check("abort_ctrl_drop", {25'd0, regA_en, regA_sel, resp_val, imm, req_rdy},
            {25'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1});
      @(negedge clk);
      reset = 1'b1;
      seen = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (resp_val || !req_rdy || regA_en) seen++;
      end
      check("abort_no_resp", seen, 0);

      // Controller resumes normally after the abort (datapath reset to 0).
      fin = '{2'b01, 4'd0, 4'd9, 4'd9, 1, 2};
      do_txn(fin, 11);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
